// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the parametrised MM:SS stopwatch core.
//   sw_state_e   : run/pause/done controller states
//   bcd_t        : one 4-bit BCD digit
//   SEC_TENS_MAX : largest legal seconds-tens digit
//   BCD_MAX      : largest legal BCD digit
//   tickTerminal : prescaler terminal count for a given speed level
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t BCD_MAX      = 4'd9;

    // Each speed level halves the tick period. Once the shifted period
    // collapses to zero the prescaler simply ticks every cycle.
    function automatic int unsigned tickTerminal(input int unsigned divBase,
                                                 input int unsigned level);
        int unsigned period;
        period = divBase >> level;
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// stopwatch_tick_gen
// Prescaler that produces the one-cycle seconds tick, plus the saturating
// speed level that sets its period (DIV_BASE >> level cycles per tick).
// Ports:
//   clk_i       : clock
//   reset_i     : synchronous active-high reset
//   countEn_i   : prescaler advances only while high (controller in RUN)
//   speedup_i   : raw speed-up button, rising edge raises the level
//   slowdown_i  : raw slow-down button, rising edge lowers the level
//   tick_o      : one-cycle pulse at the prescaler terminal count
module stopwatch_tick_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV_BASE  = 50_000_000,
    parameter int unsigned SPEED_MAX = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic countEn_i,
    input  logic speedup_i,
    input  logic slowdown_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
    localparam int unsigned LVL_W = (SPEED_MAX > 0) ? $clog2(SPEED_MAX + 1) : 1;
    localparam logic [LVL_W-1:0] LEVEL_TOP = LVL_W'(SPEED_MAX);

    logic [CNT_W-1:0] count_q, count_d, terminal;
    logic [LVL_W-1:0] level_q, level_d;
    logic             speedupPrev_q, slowdownPrev_q;
    logic             upEdge, downEdge;

    // Speed level moves one step per button edge and saturates at both ends;
    // simultaneous edges cancel. A level change restarts the prescaler so the
    // new period starts cleanly. The tick is taken from the current count, so
    // a level change in a terminal cycle still delivers that tick.
    always_comb begin
        level_d  = level_q;
        count_d  = count_q;
        upEdge   = speedup_i && !speedupPrev_q;
        downEdge = slowdown_i && !slowdownPrev_q;
        terminal = CNT_W'(tickTerminal(DIV_BASE, 32'(level_q)));
        tick_o   = countEn_i && (count_q == terminal);

        if (upEdge && !downEdge && (level_q < LEVEL_TOP)) begin
            level_d = level_q + LVL_W'(1);
        end else if (downEdge && !upEdge && (level_q != '0)) begin
            level_d = level_q - LVL_W'(1);
        end

        if (level_d != level_q) begin
            count_d = '0;
        end else if (countEn_i) begin
            count_d = tick_o ? '0 : count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q        <= '0;
            level_q        <= '0;
            speedupPrev_q  <= 1'b0;
            slowdownPrev_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            level_q        <= level_d;
            speedupPrev_q  <= speedup_i;
            slowdownPrev_q <= slowdown_i;
        end
    end

endmodule

// File: rtl/stopwatch_core_param.sv
// stopwatch_core_param
// Parametrised MM:SS stopwatch/countdown timer with BCD digit outputs for the
// seven-segment decoders.
// Optional feature macro: LAP_CAPTURE_EN (lap freeze of the displayed digits).
// Ports:
//   in_clk            : system clock
//   reset             : synchronous active-high reset
//   start             : level, 1 = run, 0 = pause
//   up                : direction (1 = up), taken only while not running
//   plus_min2         : add ADD_MIN minutes (edge detected, not in RUN)
//   speedup/slowdown  : speed level buttons (edge detected)
//   lap               : lap capture button (edge detected, LAP_CAPTURE_EN only)
//   SS0/SS1/MM0/MM1   : BCD seconds units/tens, minutes units/tens
//   running           : controller in RUN
//   done              : countdown reached 00:00
//   ovf               : sticky up-count wrap flag
module stopwatch_core_param
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV_BASE  = 50_000_000,
    parameter int unsigned SPEED_MAX = 4,
    parameter int unsigned MIN_MAX   = 99,
    parameter int unsigned ADD_MIN   = 2
) (
    input  logic in_clk,
    input  logic reset,
    input  logic start,
    input  logic up,
    input  logic plus_min2,
    input  logic speedup,
    input  logic slowdown,
    input  logic lap,
    output bcd_t SS0,
    output bcd_t SS1,
    output bcd_t MM0,
    output bcd_t MM1,
    output logic running,
    output logic done,
    output logic ovf
);

    localparam bcd_t MIN_TENS  = bcd_t'(MIN_MAX / 10);
    localparam bcd_t MIN_UNITS = bcd_t'(MIN_MAX % 10);

    sw_state_e  state_q, state_d;
    logic       dir_q, dir_d;
    bcd_t       ss0_q, ss0_d, ss1_q, ss1_d, mm0_q, mm0_d, mm1_q, mm1_d;
    logic       done_q, done_d, ovf_q, ovf_d;
    logic       plusPrev_q;
    logic       plusEdge, tick, liveZero, nextZero;
    logic [7:0] minBin, minSum, minSat;

    stopwatch_tick_gen #(
        .DIV_BASE  (DIV_BASE),
        .SPEED_MAX (SPEED_MAX)
    ) u_tick (
        .clk_i      (in_clk),
        .reset_i    (reset),
        .countEn_i  (state_q == RUN),
        .speedup_i  (speedup),
        .slowdown_i (slowdown),
        .tick_o     (tick)
    );

    // Next-state logic for the digits, flags and controller. Digits move only
    // on a tick in RUN or on a plus-minutes edge outside RUN, so the two paths
    // never compete. All arithmetic stays digit-wise BCD; minute wrap goes
    // through MIN_MAX in both directions.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        ss0_d    = ss0_q;
        ss1_d    = ss1_q;
        mm0_d    = mm0_q;
        mm1_d    = mm1_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        plusEdge = plus_min2 && !plusPrev_q;
        liveZero = (ss0_q == '0) && (ss1_q == '0) && (mm0_q == '0) && (mm1_q == '0);
        nextZero = 1'b0;
        minBin   = 8'(mm1_q) * 8'd10 + 8'(mm0_q);
        minSum   = minBin + 8'(ADD_MIN);
        minSat   = (minSum > 8'(MIN_MAX)) ? 8'(MIN_MAX) : minSum;

        if (state_q != RUN) begin
            dir_d = up;
        end

        if (tick) begin
            if (dir_q) begin
                if (ss0_q != BCD_MAX) begin
                    ss0_d = ss0_q + 4'd1;
                end else begin
                    ss0_d = '0;
                    if (ss1_q != SEC_TENS_MAX) begin
                        ss1_d = ss1_q + 4'd1;
                    end else begin
                        ss1_d = '0;
                        if ((mm1_q == MIN_TENS) && (mm0_q == MIN_UNITS)) begin
                            mm1_d = '0;
                            mm0_d = '0;
                            ovf_d = 1'b1;
                        end else if (mm0_q != BCD_MAX) begin
                            mm0_d = mm0_q + 4'd1;
                        end else begin
                            mm0_d = '0;
                            mm1_d = mm1_q + 4'd1;
                        end
                    end
                end
            end else begin
                if (ss0_q != '0) begin
                    ss0_d = ss0_q - 4'd1;
                end else begin
                    ss0_d = BCD_MAX;
                    if (ss1_q != '0) begin
                        ss1_d = ss1_q - 4'd1;
                    end else begin
                        ss1_d = SEC_TENS_MAX;
                        if ((mm1_q == '0) && (mm0_q == '0)) begin
                            mm1_d = MIN_TENS;
                            mm0_d = MIN_UNITS;
                        end else if (mm0_q != '0) begin
                            mm0_d = mm0_q - 4'd1;
                        end else begin
                            mm0_d = BCD_MAX;
                            mm1_d = mm1_q - 4'd1;
                        end
                    end
                end
                nextZero = (ss0_d == '0) && (ss1_d == '0) && (mm0_d == '0) && (mm1_d == '0);
                if (nextZero) begin
                    done_d = 1'b1;
                end
            end
        end else if (plusEdge && (state_q != RUN)) begin
            mm1_d  = bcd_t'(minSat / 8'd10);
            mm0_d  = bcd_t'(minSat % 8'd10);
            done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = PAUSE;
                end else if (tick && !dir_q && nextZero) begin
                    state_d = DONE;
                end
            end
            PAUSE: begin
                if (start) begin
                    if (!dir_q && liveZero) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = PAUSE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller, digit and flag registers; direction resets to counting up.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= 1'b1;
            ss0_q      <= '0;
            ss1_q      <= '0;
            mm0_q      <= '0;
            mm1_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            plusPrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            ss0_q      <= ss0_d;
            ss1_q      <= ss1_d;
            mm0_q      <= mm0_d;
            mm1_q      <= mm1_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            plusPrev_q <= plus_min2;
        end
    end

    assign running = (state_q == RUN);
    assign done    = done_q;
    assign ovf     = ovf_q;

`ifdef LAP_CAPTURE_EN
    logic lapPrev_q, lapShow_q, lapShow_d, lapEdge;
    bcd_t lapSs0_q, lapSs0_d, lapSs1_q, lapSs1_d, lapMm0_q, lapMm0_d, lapMm1_q, lapMm1_d;

    // Lap capture toggles a frozen snapshot of the live digits while running.
    // Leaving RUN drops the snapshot in the same edge the state changes.
    always_comb begin
        lapShow_d = lapShow_q;
        lapSs0_d  = lapSs0_q;
        lapSs1_d  = lapSs1_q;
        lapMm0_d  = lapMm0_q;
        lapMm1_d  = lapMm1_q;
        lapEdge   = lap && !lapPrev_q;

        if ((state_q != RUN) || (state_d != RUN)) begin
            lapShow_d = 1'b0;
        end else if (lapEdge) begin
            if (lapShow_q) begin
                lapShow_d = 1'b0;
            end else begin
                lapShow_d = 1'b1;
                lapSs0_d  = ss0_q;
                lapSs1_d  = ss1_q;
                lapMm0_d  = mm0_q;
                lapMm1_d  = mm1_q;
            end
        end
    end

    // Lap snapshot registers.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            lapPrev_q <= 1'b0;
            lapShow_q <= 1'b0;
            lapSs0_q  <= '0;
            lapSs1_q  <= '0;
            lapMm0_q  <= '0;
            lapMm1_q  <= '0;
        end else begin
            lapPrev_q <= lap;
            lapShow_q <= lapShow_d;
            lapSs0_q  <= lapSs0_d;
            lapSs1_q  <= lapSs1_d;
            lapMm0_q  <= lapMm0_d;
            lapMm1_q  <= lapMm1_d;
        end
    end

    assign SS0 = lapShow_q ? lapSs0_q : ss0_q;
    assign SS1 = lapShow_q ? lapSs1_q : ss1_q;
    assign MM0 = lapShow_q ? lapMm0_q : mm0_q;
    assign MM1 = lapShow_q ? lapMm1_q : mm1_q;
`else
    logic lap_unused;
    assign lap_unused = lap;

    assign SS0 = ss0_q;
    assign SS1 = ss1_q;
    assign MM0 = mm0_q;
    assign MM1 = mm1_q;
`endif

endmodule

// File: doc/stopwatch_core_param.md
Name: stopwatch_core_param

Overview:
- Parametrised MM:SS stopwatch/timer core. Successor to the fixed 4-digit stopwatch top.
- Adds:
  - configurable minute range and prescaler;
  - saturating speed control;
  - explicit run/pause/done FSM;
  - programmable minute increment;
  - overflow flag;
  - optional lap capture.
- Sits between the board clock and the BCD display path. Outputs 4-bit BCD digits to the seven-segment decoders.

Parameters:
- DIV_BASE, 50_000_000, in_clk cycles per 1 s tick at speed level 0.
- SPEED_MAX, 4, max speed level; tick period = DIV_BASE >> level.
- MIN_MAX, 99, highest minute value (2 BCD digits; 1..99).
- ADD_MIN, 2, minutes added per plus_min2 press.

Ports:
- in_clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  level: 1 = run, 0 = pause
- up  input  1  direction: 1 = count up, 0 = count down; sampled only when not running
- plus_min2  input  1  add ADD_MIN minutes; rising-edge detected internally
- speedup  input  1  increment speed level; rising-edge detected
- slowdown  input  1  decrement speed level; rising-edge detected
- lap  input  1  lap capture request; rising-edge detected (used only with LAP_CAPTURE_EN)
- SS0, SS1, MM0, MM1  output  4 each  BCD seconds units/tens, minutes units/tens
- running  output  1  FSM in RUN
- done  output  1  countdown reached 00:00
- ovf  output  1  sticky up-count wrap flag

Behaviour:
- Interface: one clock (in_clk); reset is synchronous and active-high.
- Reset values:
  - all digits 0; state IDLE; speed level 0; prescaler 0;
  - dir = 1 (up); running, done, ovf = 0;
  - edge-detect registers 0.
- Prescaler (sub-module):
  - counts 0..(DIV_BASE >> level) - 1; emits a 1-cycle tick at the terminal count, then restarts at 0.
  - Counts only in RUN; holds its value in other states.
  - Level changes reset the count to 0.
- Speed level:
  - speedup edge: +1, saturating at SPEED_MAX.
  - slowdown edge: -1, saturating at 0.
  - Both edges in the same cycle: no change.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: start=0 -> PAUSE. Down-count tick producing 00:00 -> DONE.
  - PAUSE: start=1 -> RUN, except down-mode at 00:00 -> DONE.
  - DONE: start=0 -> PAUSE.
- Direction: dir <= up every cycle in IDLE/PAUSE/DONE; frozen in RUN.
- Tick, up-count:
  - SS increments; SS 59 -> 00 with minute +1.
  - At MIN_MAX:59 -> 00:00 and ovf <= 1. ovf is cleared only by reset.
- Tick, down-count:
  - SS decrements; SS 00 -> 59 with minute -1.
  - Reaching 00:00 sets done=1 in the same update.
- plus_min2 edge:
  - accepted in IDLE/PAUSE/DONE; ignored in RUN;
  - minutes = min(minutes + ADD_MIN, MIN_MAX); seconds unchanged;
  - clears done.
- Arithmetic:
  - minute and second values are kept in BCD, with digit-wise carry/borrow;
  - no digit ever holds a value > 9; SS1 never holds a value > 5.
- Latency: digit registers update on the clock edge after the tick cycle. Outputs are registered.
- reset overrides all other inputs in the same cycle, including mid-count and mid-edge.

Optional Feature:
- Macro: LAP_CAPTURE_EN.
- Defined:
  - a lap edge in RUN copies the live digits into a lap register and sets lap_show;
  - while lap_show=1, outputs show the lap register and the live count keeps running underneath;
  - a second lap edge, or leaving RUN, clears lap_show;
  - a lap edge outside RUN is ignored.
- Undefined: no lap register; the lap port is unused; outputs always show the live digits.

Decomposition:
- Package stopwatch_pkg:
  - sw_state_e enum (IDLE, RUN, PAUSE, DONE);
  - bcd_t typedef, logic [3:0];
  - SEC_TENS_MAX = 5 and BCD_MAX = 9 constants;
  - a function that converts the speed level to the prescaler terminal count.
- Sub-module stopwatch_tick_gen: prescaler plus saturating speed level, including its own speedup/slowdown edge detection.

Test Plan (bench uses DIV_BASE=4, SPEED_MAX=2, MIN_MAX=3, ADD_MIN=2):
- Reset, then start=1 with up=1 for 4*60 cycles -> outputs 01:00, running=1, ovf=0.
- Up count from 03:59 on one tick -> 00:00, ovf=1; ovf stays 1 until reset.
- In PAUSE at 00:00 with up=0, pulse plus_min2 twice -> 03:00 (saturated at MIN_MAX). Then start=1 with 180 ticks -> 00:00, done=1, state DONE; start=0 -> PAUSE.
- Pulse speedup 3 times -> level 2 (saturated); tick every cycle. Pulse speedup and slowdown in the same cycle -> level unchanged.
- RUN at 00:07, assert reset for 1 cycle with start=1 -> next cycle 00:00, IDLE, level 0, flags 0.
- LAP_CAPTURE_EN: lap edge at 00:05 -> outputs stay at 00:05 while the live count advances to 00:09; second lap edge -> outputs show 00:09.
